shadow_regbank: RTL and testbench

//  Parametrised bank of NREGS control registers with byte-enabled writes into shadow copies, atomic commit to active copies,

---
 rtl/shadow_regbank_pkg.sv | 30 +++
 rtl/shadow_regbank_slot.sv | 44 ++++
 rtl/shadow_regbank.sv | 103 ++++++++++
 tb/tb_shadow_regbank.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_regbank_pkg.sv
// Shared helpers for shadow_regbank: a constant-capable clog2 and the byte-merge used on shadow writes.
// The merge operates at the widest supported register width; callers cast to their own width.
package shadow_regbank_pkg;

  localparam int MAX_DATAW = 64;
  localparam int MAX_BEW   = MAX_DATAW / 8;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

  function automatic logic [MAX_DATAW-1:0] merge(input logic [MAX_DATAW-1:0] old_v,
                                                 input logic [MAX_DATAW-1:0] new_v,
                                                 input logic [MAX_BEW-1:0]   be);
    logic [MAX_DATAW-1:0] res;
    for (int k = 0; k < MAX_BEW; k++) begin
      res[8*k +: 8] = be[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/shadow_regbank_slot.sv
// One control register: a shadow copy that takes byte-merged writes and an active copy
// loaded from the (possibly just-written) shadow on commit.
module regbank_slot
  import shadow_regbank_pkg::*;
#(
  parameter int               DATAW  = 32,
  parameter logic [DATAW-1:0] RSTVAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [DATAW/8-1:0] i_be,
  input  logic [DATAW-1:0]   i_data,
  input  logic               i_commit,
  output logic [DATAW-1:0]   o_active
);

  logic [DATAW-1:0] shadow_q;
  logic [DATAW-1:0] shadow_d;
  logic [DATAW-1:0] active_q;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    shadow_d = shadow_q;
    if (i_we) begin
      shadow_d = DATAW'(merge(MAX_DATAW'(shadow_q), MAX_DATAW'(i_data), MAX_BEW'(i_be)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_q <= RSTVAL;
      active_q <= RSTVAL;
    end else begin
      shadow_q <= shadow_d;
      // Commit takes shadow_d so a same-cycle write is included.
      if (i_commit) active_q <= shadow_d;
    end
  end

  assign o_active = active_q;

endmodule

// File: rtl/shadow_regbank.sv
// Shadowed control-register bank with atomic commit, registered read port and range errors.
// Optional macro SHADOW_REGBANK_XOR_EN adds a registered XOR reduction of all active bits on o_xor.
module shadow_regbank
  import shadow_regbank_pkg::*;
#(
  parameter int               DATAW  = 32,
  parameter int               NREGS  = 8,
  parameter logic [DATAW-1:0] RSTVAL = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic                   i_re,
  input  logic [7:0]             i_addr,
  input  logic [DATAW/8-1:0]     i_be,
  input  logic [DATAW-1:0]       i_data,
  input  logic                   i_commit,
  output logic [DATAW-1:0]       o_data,
  output logic                   o_rvalid,
  output logic                   o_err,
  output logic                   o_pending,
  output logic [NREGS*DATAW-1:0] o_regs,
  output logic                   o_xor
);

  localparam int BEW  = DATAW / 8;
  localparam int IDXW = clog2(NREGS);

  logic             in_range;
  logic [IDXW-1:0]  idx;
  logic [DATAW-1:0] active [NREGS];
  logic [DATAW-1:0] rd_word;

  logic [DATAW-1:0] data_q;
  logic             rvalid_q;
  logic             err_q;
  logic             pending_q;

  // Full 8-bit compare: index bits above IDXW must also be in range.
  assign in_range = ({1'b0, i_addr} < 9'(NREGS));
  assign idx      = i_addr[IDXW-1:0];

  for (genvar n = 0; n < NREGS; n++) begin : g_slot
    regbank_slot #(
      .DATAW  (DATAW),
      .RSTVAL (RSTVAL)
    ) u_slot (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we     (i_we && in_range && (idx == IDXW'(n))),
      .i_be     (i_be),
      .i_data   (i_data),
      .i_commit (i_commit),
      .o_active (active[n])
    );
    assign o_regs[n*DATAW +: DATAW] = active[n];
  end

  always_comb begin
    rd_word = '0;
    for (int n = 0; n < NREGS; n++) begin
      if (in_range && (idx == IDXW'(n))) rd_word = active[n];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q    <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      rvalid_q <= i_re;
      err_q    <= (i_we || i_re) && !in_range;
      if (i_re) data_q <= rd_word;
      if (i_commit)                pending_q <= 1'b0;
      else if (i_we && in_range)   pending_q <= 1'b1;
    end
  end

  assign o_data    = data_q;
  assign o_rvalid  = rvalid_q;
  assign o_err     = err_q;
  assign o_pending = pending_q;

`ifdef SHADOW_REGBANK_XOR_EN
  logic xor_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) xor_q <= ^{NREGS{RSTVAL}};
    else       xor_q <= ^o_regs;
  end

  assign o_xor = xor_q;
`else
  assign o_xor = 1'b0;
`endif

  // BEW documents the byte-enable width; it is the width of i_be.
  logic [BEW-1:0] be_unused_chk;
  assign be_unused_chk = i_be;

endmodule

// File: tb/tb_shadow_regbank.sv
// Randomised bench for shadow_regbank: a behavioural model predicts every cycle's outputs
// into a queue; a monitor pops and compares after each clock edge.
module tb_shadow_regbank;

  localparam int               DATAW  = 32;
  localparam int               NREGS  = 8;
  localparam logic [DATAW-1:0] RSTVAL = '0;
  localparam int               BEW    = DATAW / 8;
  localparam int               W      = NREGS * DATAW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             we = 1'b0, re = 1'b0, commit = 1'b0;
  logic [7:0]       addr = '0;
  logic [BEW-1:0]   be = '0;
  logic [DATAW-1:0] wdata = '0;

  logic [DATAW-1:0] o_data;
  logic             o_rvalid, o_err, o_pending, o_xor;
  logic [W-1:0]     o_regs;

  shadow_regbank #(.DATAW(DATAW), .NREGS(NREGS), .RSTVAL(RSTVAL)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_we      (we),
    .i_re      (re),
    .i_addr    (addr),
    .i_be      (be),
    .i_data    (wdata),
    .i_commit  (commit),
    .o_data    (o_data),
    .o_rvalid  (o_rvalid),
    .o_err     (o_err),
    .o_pending (o_pending),
    .o_regs    (o_regs),
    .o_xor     (o_xor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rvalid;
    logic [DATAW-1:0] data;
    logic             err;
    logic             pending;
    logic [W-1:0]     regs;
    logic             xr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [DATAW-1:0] m_shadow [NREGS];
  logic [DATAW-1:0] m_active [NREGS];
  logic             m_pending;
  logic [DATAW-1:0] m_data;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] flat_active();
    logic [W-1:0] f;
    for (int n = 0; n < NREGS; n++) f[n*DATAW +: DATAW] = m_active[n];
    return f;
  endfunction

  function automatic logic parity_active();
    int ones = 0;
    for (int n = 0; n < NREGS; n++) ones += $countones(m_active[n]);
    return ones[0];
  endfunction

  // One bus cycle: drive inputs at the falling edge and predict the state after the next rising edge.
  task automatic cyc(input logic r, input logic w, input logic rd, input logic c,
                     input logic [7:0] a, input logic [BEW-1:0] b, input logic [DATAW-1:0] d);
    exp_t e;
    logic [DATAW-1:0] mask;
    bit oor;
    @(negedge clk);
    rst = r; we = w; re = rd; commit = c; addr = a; be = b; wdata = d;
    oor = (int'(a) >= NREGS);
    if (r) begin
      for (int n = 0; n < NREGS; n++) begin
        m_shadow[n] = RSTVAL;
        m_active[n] = RSTVAL;
      end
      m_pending = 1'b0;
      m_data    = '0;
      e.rvalid  = 1'b0;
      e.err     = 1'b0;
      e.xr      = parity_active();
    end else begin
      e.xr     = parity_active();
      e.rvalid = rd;
      e.err    = (w || rd) && oor;
      if (rd) m_data = oor ? '0 : m_active[a];
      if (w && !oor) begin
        mask = '0;
        for (int k = 0; k < BEW; k++) if (b[k]) mask = mask | (DATAW'(8'hFF) << (8 * k));
        m_shadow[a] = (m_shadow[a] & ~mask) | (d & mask);
        m_pending   = 1'b1;
      end
      if (c) begin
        for (int n = 0; n < NREGS; n++) m_active[n] = m_shadow[n];
        m_pending = 1'b0;
      end
    end
`ifndef SHADOW_REGBANK_XOR_EN
    e.xr = 1'b0;
`endif
    e.data    = m_data;
    e.pending = m_pending;
    e.regs    = flat_active();
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, '0, '0);
  endtask

  // Monitor: compares every predicted cycle once its edge has passed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rvalid",  W'(o_rvalid),  W'(e.rvalid));
        check("err",     W'(o_err),     W'(e.err));
        check("pending", W'(o_pending), W'(e.pending));
        check("regs",    o_regs,        e.regs);
        check("xor",     W'(o_xor),     W'(e.xr));
        if (e.rvalid) check("rdata", W'(o_data), W'(e.data));
        else          check("data_hold", W'(o_data), W'(e.data));
      end
    end
  end

  initial begin
    int budget;
    logic [7:0] a;
    for (int n = 0; n < NREGS; n++) begin
      m_shadow[n] = RSTVAL;
      m_active[n] = RSTVAL;
    end
    m_pending = 1'b0;
    m_data    = '0;

    // Reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0, '0);
    idle();

    // Partial-byte write is invisible until commit
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 4'b0101, 32'hAABBCCDD);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd3, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd3, '0, '0);
    idle();

    // Write with same-cycle commit
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 4'b1111, 32'h00000011);
    idle();

    // Out-of-range write, read, and both together
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd8, 4'b1111, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd200, '0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'd255, 4'b1111, 32'h12345678);
    idle();

    // Same-cycle write and read returns old active value
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 4'b1111, 32'hCAFEF00D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd4, '0, '0);

    // Zero byte-enable write still marks pending
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 4'b0000, 32'hFFFFFFFF);
    idle();

    // Reset discards uncommitted writes and a read in the reset cycle
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 4'b1111, 32'h22222222);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 4'b1111, 32'h55555555);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd2, '0, '0);
    idle();

    // Single set bit committed to reg 0
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 4'b0001, 32'h00000001);
    idle();
    idle();
    idle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(NREGS, 255)) : 8'($urandom_range(0, NREGS - 1));
      cyc(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 7) == 0), a, BEW'($urandom), DATAW'($urandom));
    end
    idle();

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    check("drain", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
